// File: rtl/round_sequencer_pkg.sv
// Shared types and helpers for the round sequencer: FSM states, the 4x4 byte block view,
// pack/unpack between the 128-bit bus layout and the array, and the GF(2^8) doubling step.
package round_sequencer_pkg;

    typedef enum logic [1:0] {IDLE, KEY, DONE} fsm_t;

    // blk[r][c] is byte (row r, column c); bus byte index is 4*r+c
    typedef logic [3:0][3:0][7:0] blk_t;

    function automatic blk_t unpack_blk(input logic [127:0] v);
        blk_t a;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = v[8*(4*r+c) +: 8];
        return a;
    endfunction

    function automatic logic [127:0] pack_blk(input blk_t a);
        logic [127:0] v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[8*(4*r+c) +: 8] = a[r][c];
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Block-in / key-fetch / block-out signal bundle of the round sequencer.
interface round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         key_req;
    logic [3:0]   key_round;
    logic         key_valid;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, key_valid, round_key, out_ready,
        input  in_ready, key_req, key_round, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, key_valid, round_key, out_ready,
        output in_ready, key_req, key_round, out_valid, out_state, busy
    );
endinterface

// File: rtl/round_sequencer_diffusion.sv
// Combinational column diffusion: each column is multiplied by the circulant
// matrix [2 3 1 1] over GF(2^8) (reduction polynomial 0x11b).
module round_sequencer_diffusion
    import round_sequencer_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);
    blk_t a, b;

    assign a = unpack_blk(din);

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign b[0][c] = xtime(a[0][c]) ^ xtime(a[1][c]) ^ a[1][c] ^ a[2][c] ^ a[3][c];
        assign b[1][c] = a[0][c] ^ xtime(a[1][c]) ^ xtime(a[2][c]) ^ a[2][c] ^ a[3][c];
        assign b[2][c] = a[0][c] ^ a[1][c] ^ xtime(a[2][c]) ^ xtime(a[3][c]) ^ a[3][c];
        assign b[3][c] = xtime(a[0][c]) ^ a[0][c] ^ a[1][c] ^ a[2][c] ^ xtime(a[3][c]);
    end

    assign dout = pack_blk(b);
endmodule

// File: rtl/round_sequencer.sv
// Iterative round sequencer: whitening, NUM_ROUNDS keyed rounds fetched one key per cycle.
// Build option ROUND_SEQ_FINAL_DIFFUSION_EN also applies diffusion in the last round.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic clk,
    input  logic reset,
    round_sequencer_if.slave bus
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] st_q, st_d, diff;
    logic [3:0]   cnt_q, cnt_d;

    round_sequencer_diffusion u_diff (
        .din  (st_q),
        .dout (diff)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        st_d          = st_q;
        cnt_d         = cnt_q;
        bus.in_ready  = 1'b0;
        bus.key_req   = 1'b0;
        bus.out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    st_d  = bus.in_state;
                    cnt_d = '0;
                    fsm_d = KEY;
                end
            end
            KEY: begin
                bus.key_req = 1'b1;
                if (bus.key_valid) begin
                    if (cnt_q == 4'd0) begin
                        st_d = st_q ^ bus.round_key;
                    end else if (cnt_q < LAST) begin
                        st_d = diff ^ bus.round_key;
                    end else begin
`ifdef ROUND_SEQ_FINAL_DIFFUSION_EN
                        st_d = diff ^ bus.round_key;
`else
                        st_d = st_q ^ bus.round_key;
`endif
                        fsm_d = DONE;
                    end
                    // counter saturates at the final round index
                    if (cnt_q < LAST)
                        cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.key_round = cnt_q;
    assign bus.out_state = st_q;
    assign bus.busy      = (fsm_q != IDLE);
endmodule

// File: tb/tb_round_sequencer.sv
// Directed-random bench for round_sequencer at NUM_ROUNDS 1, 10 and 15 against a
// byte-level reference of the whitening/diffusion/key schedule.
module tb_round_sequencer;
    localparam int NR[3] = '{1, 10, 15};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int           sel = 1;
    logic         in_valid = 1'b0;
    logic [127:0] in_state = '0;
    logic         key_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] keys [16];
    logic [127:0] rk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         in_ready;
        logic         key_req;
        logic [3:0]   key_round;
        logic         out_valid;
        logic [127:0] out_state;
        logic         busy;
    } obs_t;

    obs_t o0, o1, o2, ob;

    round_sequencer_if b0 ();
    round_sequencer_if b1 ();
    round_sequencer_if b2 ();

    round_sequencer #(.NUM_ROUNDS(1))  dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    round_sequencer #(.NUM_ROUNDS(10)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    round_sequencer #(.NUM_ROUNDS(15)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    assign b0.in_valid  = in_valid  && sel == 0;
    assign b1.in_valid  = in_valid  && sel == 1;
    assign b2.in_valid  = in_valid  && sel == 2;
    assign b0.key_valid = key_valid && sel == 0;
    assign b1.key_valid = key_valid && sel == 1;
    assign b2.key_valid = key_valid && sel == 2;
    assign b0.out_ready = out_ready && sel == 0;
    assign b1.out_ready = out_ready && sel == 1;
    assign b2.out_ready = out_ready && sel == 2;
    assign b0.in_state  = in_state;
    assign b1.in_state  = in_state;
    assign b2.in_state  = in_state;
    assign b0.round_key = rk;
    assign b1.round_key = rk;
    assign b2.round_key = rk;

    assign o0 = {b0.in_ready, b0.key_req, b0.key_round, b0.out_valid, b0.out_state, b0.busy};
    assign o1 = {b1.in_ready, b1.key_req, b1.key_round, b1.out_valid, b1.out_state, b1.busy};
    assign o2 = {b2.in_ready, b2.key_req, b2.key_round, b2.out_valid, b2.out_state, b2.busy};
    assign ob = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;
    assign rk = keys[ob.key_round];

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // generic shift-and-add multiply in GF(2^8)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x, y;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] v);
        logic [7:0]   s [4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        int           coef [4];
        coef = '{2, 3, 1, 1};
        res  = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = v[8*(4*r+c) +: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[k][c], 8'(coef[(k - r) & 3]));
                res[8*(4*r+c) +: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input int n);
        logic [127:0] s;
        s = blk ^ keys[0];
        for (int i = 1; i < n; i++)
            s = mixcols(s) ^ keys[i];
`ifdef ROUND_SEQ_FINAL_DIFFUSION_EN
        s = mixcols(s) ^ keys[n];
`else
        s = s ^ keys[n];
`endif
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_keys(input bit zero);
        for (int i = 0; i < 16; i++) keys[i] = zero ? '0 : rand128();
    endtask

    // One block on DUT s; optional key stall at a round, delayed out_ready,
    // garbage on in_state/in_valid while busy, or a reset at a given round.
    task automatic run(input int s, input logic [127:0] blk, input int stall_rnd,
                       input int ready_lo, input bit junk, input int abort_rnd);
        int           n, lat, stalled, extra;
        logic [127:0] exp, held;
        n       = NR[s];
        sel     = s;
        exp     = model(blk, n);
        stalled = 0;
        #1;
        check("idle_in_ready", ob.in_ready, 1);
        in_state  = blk;
        in_valid  = 1'b1;
        key_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        if (junk) in_state = rand128(); else in_valid = 1'b0;
        while (!ob.out_valid && lat < 200) begin
            if (abort_rnd >= 0 && ob.key_round == 4'(abort_rnd)) begin
                reset = 1'b1;
                #1;
                check("rst_out_state", ob.out_state, 0);
                check("rst_key_req",   ob.key_req,   0);
                check("rst_busy",      ob.busy,      0);
                check("rst_out_valid", ob.out_valid, 0);
                check("rst_key_round", ob.key_round, 0);
                check("rst_in_ready",  ob.in_ready,  1);
                in_valid  = 1'b0;
                key_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (stall_rnd >= 0 && ob.key_round == 4'(stall_rnd) && stalled == 0) begin
                held      = ob.out_state;
                key_valid = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    lat++;
                    check("stall_key_req",   ob.key_req,   1);
                    check("stall_key_round", ob.key_round, stall_rnd);
                    check("stall_state",     ob.out_state, held);
                end
                key_valid = 1'b1;
                stalled   = 1;
            end
            @(posedge clk); #1;
            lat++;
            if (junk) in_state = rand128();
        end
        check("latency", lat, n + 2 + (stalled ? 3 : 0));
        check("result",  ob.out_state, exp);
        in_valid  = 1'b0;
        key_valid = 1'b0;
        held      = ob.out_state;
        repeat (ready_lo) begin
            @(posedge clk); #1;
            check("hold_out_valid", ob.out_valid, 1);
            check("hold_out_state", ob.out_state, held);
            check("hold_in_ready",  ob.in_ready,  0);
        end
        // offer a new block during the output handshake: it must not be taken
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = rand128();
        check("hs_in_ready", ob.in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_in_ready",  ob.in_ready,  1);
        check("post_out_valid", ob.out_valid, 0);
        check("post_busy",      ob.busy,      0);
        if (junk) begin
            extra = 0;
            repeat (n + 4) begin
                @(posedge clk); #1;
                if (ob.out_valid) extra++;
            end
            check("single_output", extra, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        new_keys(1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_in_ready",  ob.in_ready,  1);
            check("reset_key_req",   ob.key_req,   0);
            check("reset_key_round", ob.key_round, 0);
            check("reset_out_valid", ob.out_valid, 0);
            check("reset_out_state", ob.out_state, 0);
            check("reset_busy",      ob.busy,      0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // all-zero block and keys on the 10-round instance
        new_keys(1'b1);
        run(1, '0, -1, 0, 1'b0, -1);

        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 3; k++) begin
                new_keys(1'b0);
                run(s, rand128(), -1, 0, 1'b0, -1);
            end

        new_keys(1'b0);
        run(1, rand128(), 4, 0, 1'b0, -1);

        new_keys(1'b0);
        run(1, rand128(), -1, 5, 1'b0, -1);

        new_keys(1'b0);
        run(1, rand128(), -1, 0, 1'b0, 5);
        new_keys(1'b0);
        run(1, rand128(), -1, 0, 1'b0, -1);

        new_keys(1'b0);
        run(2, rand128(), -1, 2, 1'b1, -1);
        new_keys(1'b0);
        run(0, rand128(), -1, 0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10: number of keyed rounds after initial whitening; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: input block offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept input.
REQ-006 The block SHALL have port in_state, input, 128 bits: input block; byte [r][c] = in_state[8*(4*r+c)+:8].
REQ-007 The block SHALL have port key_req, output, 1 bit: round key requested.
REQ-008 The block SHALL have port key_round, output, 4 bits: index of the requested round key.
REQ-009 The block SHALL have port key_valid, input, 1 bit: round_key is valid for key_round.
REQ-010 The block SHALL have port round_key, input, 128 bits: round key, with the same byte mapping as in_state.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port out_state, output, 128 bits: result block, with the same byte mapping as in_state.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, KEY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an in_valid&in_ready cycle SHALL load the state register from in_state, set the round counter to 0 and move to KEY.
REQ-017 In KEY, key_req SHALL be 1 and key_round SHALL equal the round counter; key_valid SHALL be ignored outside KEY.
REQ-018 In KEY, a key_valid cycle with counter=0 SHALL set state to state^round_key.
REQ-019 In KEY, a key_valid cycle with 1<=counter<NUM_ROUNDS SHALL set state to diffusion(state)^round_key.
REQ-020 In KEY, a key_valid cycle with counter=NUM_ROUNDS SHALL set state to state^round_key and move to DONE; see REQ-029 for the configured alternative.
REQ-021 In KEY, a key_valid=0 cycle SHALL hold the state register, the counter and key_round unchanged.
REQ-022 The counter SHALL increment on every accepted key and SHALL never exceed NUM_ROUNDS.
REQ-023 Minimum latency SHALL be NUM_ROUNDS+2 cycles from input handshake to out_valid, with key_valid held high.
REQ-024 In DONE, out_valid SHALL be 1 and out_state SHALL hold the state register stable until out_valid&out_ready; the FSM SHALL then return to IDLE.
REQ-025 The block SHALL NOT accept a new input in the cycle of the output handshake; in_ready SHALL rise the following cycle.

Reset
REQ-026 Reset SHALL force, asynchronously and at any point including mid-round or in DONE: FSM=IDLE, state register=0, counter=0.
REQ-027 During and after reset the outputs SHALL be: in_ready=1, key_req=0, key_round=0, out_valid=0, out_state=0, busy=0.
REQ-028 A block in flight when reset asserts SHALL be discarded with no partial output.

Configuration
REQ-029 When macro ROUND_SEQ_FINAL_DIFFUSION_EN is defined, the final round SHALL also apply diffusion, i.e. diffusion(state)^round_key.
REQ-030 When ROUND_SEQ_FINAL_DIFFUSION_EN is undefined, the final round SHALL skip diffusion as stated in REQ-020.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the 4x4-byte state array typedef, and the pack/unpack functions between 128-bit vectors and the array.
REQ-032 The block SHALL instantiate the existing combinational diffusion module as its single sub-module, with input = state register, output = the next-state datapath.

Verification
REQ-033 Scenario: NUM_ROUNDS=10, in_state=0, all keys 0, key_valid tied 1 -> out_state=0 and out_valid exactly 12 cycles after the input handshake.
REQ-034 Scenario: random in_state and keys -> out_state matches the reference model for round counts 1, 10 and 15, both with and without ROUND_SEQ_FINAL_DIFFUSION_EN.
REQ-035 Scenario: key_valid held low 3 cycles while key_round=4 -> key_req=1, key_round=4, state unchanged for those cycles; final result unchanged versus the no-stall run.
REQ-036 Scenario: out_ready low 5 cycles in DONE -> out_valid=1, out_state stable, in_ready=0 throughout; one cycle after the handshake in_ready=1.
REQ-037 Scenario: reset pulsed while key_round=5 -> out_state=0, key_req=0, busy=0 immediately; next block from IDLE produces the correct result.
REQ-038 Scenario: in_valid=1 while busy -> input ignored, in_state changes have no effect, and a single out_valid handshake occurs.
